// File: rtl/calc_keypad_pkg.sv
// Types and constants shared by the keypad front end and the calculator controller.
// Key codes, operator one-hots, debounce FSM states and the per-frame scan result.
package calc_keypad_pkg;

  typedef enum logic [3:0] {
    KEY_0    = 4'd0,
    KEY_1    = 4'd1,
    KEY_2    = 4'd2,
    KEY_3    = 4'd3,
    KEY_4    = 4'd4,
    KEY_5    = 4'd5,
    KEY_6    = 4'd6,
    KEY_7    = 4'd7,
    KEY_8    = 4'd8,
    KEY_9    = 4'd9,
    KEY_A    = 4'd10,
    KEY_B    = 4'd11,
    KEY_C    = 4'd12,
    KEY_D    = 4'd13,
    KEY_STAR = 4'd14,
    KEY_HASH = 4'd15
  } key_code_t;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } kp_state_t;

  typedef enum logic [1:0] {
    FR_NONE  = 2'd0,
    FR_KEY   = 2'd1,
    FR_MULTI = 2'd2
  } frame_res_t;

  function automatic key_code_t key_at(input logic [1:0] row, input logic [1:0] col);
    key_code_t k;
    case ({row, col})
      4'd0:    k = KEY_1;
      4'd1:    k = KEY_2;
      4'd2:    k = KEY_3;
      4'd3:    k = KEY_A;
      4'd4:    k = KEY_4;
      4'd5:    k = KEY_5;
      4'd6:    k = KEY_6;
      4'd7:    k = KEY_B;
      4'd8:    k = KEY_7;
      4'd9:    k = KEY_8;
      4'd10:   k = KEY_9;
      4'd11:   k = KEY_C;
      4'd12:   k = KEY_STAR;
      4'd13:   k = KEY_0;
      4'd14:   k = KEY_HASH;
      default: k = KEY_D;
    endcase
    return k;
  endfunction

  // '*' and 'D' are debounced like any key but never reach the controller.
  function automatic logic key_has_event(input key_code_t k);
    return (k != KEY_STAR) && (k != KEY_D);
  endfunction

endpackage

// File: rtl/keypad_row_scanner.sv
// Drives one matrix row low at a time and condenses each four-row sweep into
// a frame result (NONE / single KEY / MULTI) with a one-cycle frame-done pulse.
module keypad_row_scanner
  import calc_keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [3:0] i_col,
  output logic [3:0] o_row,
  output logic       o_frame_done,
  output frame_res_t o_frame_res,
  output key_code_t  o_frame_code
);

  localparam int            DW        = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] SLOT_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] r_slot_cnt;
  logic [1:0]    r_row_idx;
  logic [3:0]    r_row_out;
  logic [1:0]    r_hits;
  key_code_t     r_code;
  logic          r_frame_done;
  frame_res_t    r_frame_res;
  key_code_t     r_frame_code;

  logic          w_slot_end;
  logic [2:0]    w_row_hits;
  logic [1:0]    w_row_col;
  logic [2:0]    w_hits_sum;
  logic [1:0]    w_hits_sat;
  key_code_t     w_code;

  // Hit count saturates at two: beyond that only "more than one key" matters.
  always_comb begin
    w_slot_end = (r_slot_cnt == SLOT_LAST);
    w_row_hits = 3'd0;
    w_row_col  = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (!i_col[c]) begin
        w_row_hits = w_row_hits + 3'd1;
        w_row_col  = 2'(c);
      end
    end
    w_hits_sum = {1'b0, r_hits} + w_row_hits;
    w_hits_sat = (w_hits_sum >= 3'd2) ? 2'd2 : w_hits_sum[1:0];
    w_code     = ((r_hits == 2'd0) && (w_row_hits == 3'd1)) ? key_at(r_row_idx, w_row_col) : r_code;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_slot_cnt   <= '0;
      r_row_idx    <= 2'd0;
      r_row_out    <= 4'b1110;
      r_hits       <= 2'd0;
      r_code       <= KEY_0;
      r_frame_done <= 1'b0;
      r_frame_res  <= FR_NONE;
      r_frame_code <= KEY_0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_slot_end) begin
        r_slot_cnt <= '0;
        r_row_idx  <= r_row_idx + 2'd1;
        r_row_out  <= {r_row_out[2:0], r_row_out[3]};
        if (r_row_idx == 2'd3) begin
          r_frame_done <= 1'b1;
          r_frame_res  <= (w_hits_sat == 2'd0) ? FR_NONE :
                          (w_hits_sat == 2'd1) ? FR_KEY  : FR_MULTI;
          r_frame_code <= w_code;
          r_hits       <= 2'd0;
          r_code       <= KEY_0;
        end else begin
          r_hits <= w_hits_sat;
          r_code <= w_code;
        end
      end else begin
        r_slot_cnt <= r_slot_cnt + DW'(1);
      end
    end
  end

  assign o_row        = r_row_out;
  assign o_frame_done = r_frame_done;
  assign o_frame_res  = r_frame_res;
  assign o_frame_code = r_frame_code;

endmodule

// File: rtl/keypad_encoder.sv
// Keypad front end: debounces scan frames into confirmed presses and hands them
// to the controller as one-cycle strobes through a one-entry holding buffer.
module keypad_encoder
  import calc_keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       RST,
  output logic [3:0] row_out,
  input  logic [3:0] col_in,
  input  logic       accept,
  output logic [3:0] keypad_input,
  output logic       read_input,
  output logic [2:0] operator_input,
  output logic       equal_input,
  output logic       overrun
);

  localparam int            CW       = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic       w_frame_done;
  frame_res_t w_frame_res;
  key_code_t  w_frame_code;

  kp_state_t     r_state;
  logic [CW-1:0] r_cnt;
  key_code_t     r_press_code;
  logic          r_evt_pulse;
  key_code_t     r_evt_code;
  logic          r_buf_valid;
  key_code_t     r_buf_code;
  logic [3:0]    r_keypad;
  logic          r_read;
  logic [2:0]    r_op;
  logic          r_equal;
  logic          r_overrun;

  logic [CW-1:0] w_cnt_inc;
  logic          w_new_evt;
  logic          w_emit;

  keypad_row_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
    .clk          (clk),
    .RST          (RST),
    .i_col        (col_in),
    .o_row        (row_out),
    .o_frame_done (w_frame_done),
    .o_frame_res  (w_frame_res),
    .o_frame_code (w_frame_code)
  );

  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_new_evt = r_evt_pulse && key_has_event(r_evt_code);
  assign w_emit    = r_buf_valid && accept;

  // Debounce FSM: MULTI frames clear the counter but never change state.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_press_code <= KEY_0;
      r_evt_pulse  <= 1'b0;
      r_evt_code   <= KEY_0;
    end else begin
      r_evt_pulse <= 1'b0;
      if (w_frame_done) begin
        case (r_state)
          ST_IDLE: begin
            r_cnt <= '0;
            if (w_frame_res == FR_KEY) begin
              r_press_code <= w_frame_code;
              if (CNT_DONE == CNT_ONE) begin
                r_state     <= ST_HELD;
                r_evt_pulse <= 1'b1;
                r_evt_code  <= w_frame_code;
              end else begin
                r_state <= ST_PRESS_DB;
                r_cnt   <= CNT_ONE;
              end
            end
          end
          ST_PRESS_DB: begin
            if (w_frame_res == FR_MULTI) begin
              r_cnt <= '0;
            end else if (w_frame_res == FR_KEY && w_frame_code == r_press_code) begin
              if (w_cnt_inc == CNT_DONE) begin
                r_state     <= ST_HELD;
                r_cnt       <= '0;
                r_evt_pulse <= 1'b1;
                r_evt_code  <= r_press_code;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end
          end
          ST_HELD: begin
            r_cnt <= '0;
            if (w_frame_res == FR_NONE) begin
              if (CNT_DONE == CNT_ONE) begin
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_RELEASE_DB;
                r_cnt   <= CNT_ONE;
              end
            end
          end
          default: begin
            if (w_frame_res == FR_MULTI) begin
              r_cnt <= '0;
            end else if (w_frame_res == FR_KEY) begin
              r_state <= ST_HELD;
              r_cnt   <= '0;
            end else if (w_cnt_inc == CNT_DONE) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        endcase
      end
    end
  end

  // Holding buffer and registered strobes; an emit frees the slot for a same-cycle latch.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_buf_valid <= 1'b0;
      r_buf_code  <= KEY_0;
      r_keypad    <= 4'd0;
      r_read      <= 1'b0;
      r_op        <= 3'b000;
      r_equal     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_read    <= 1'b0;
      r_op      <= 3'b000;
      r_equal   <= 1'b0;
      r_overrun <= 1'b0;
      if (w_emit) begin
        case (r_buf_code)
          KEY_A:    r_op    <= OP_ADD;
          KEY_B:    r_op    <= OP_SUB;
          KEY_C:    r_op    <= OP_MUL;
          KEY_HASH: r_equal <= 1'b1;
          KEY_D, KEY_STAR: ;
          default: begin
            r_read   <= 1'b1;
            r_keypad <= r_buf_code;
          end
        endcase
        r_buf_valid <= w_new_evt;
        if (w_new_evt) r_buf_code <= r_evt_code;
      end else if (w_new_evt) begin
        if (r_buf_valid) begin
          r_overrun <= 1'b1;
        end else begin
          r_buf_valid <= 1'b1;
          r_buf_code  <= r_evt_code;
        end
      end
    end
  end

  assign keypad_input   = r_keypad;
  assign read_input     = r_read;
  assign operator_input = r_op;
  assign equal_input    = r_equal;
  assign overrun        = r_overrun;

endmodule

// File: doc/keypad_encoder.md
# keypad_encoder

Front end of the 16-bit signed calculator. It scans a 4x4 active-low key matrix, debounces presses, and encodes each confirmed key into the single-cycle event pulses the calculator controller consumes:

- `keypad_input` with `read_input` for digits;
- `operator_input` (one-hot) for operators;
- `equal_input` for equals.

A one-entry holding buffer lets the controller throttle events with `accept`.

## Interface

Parameters:

- SCAN_DIV, 1000: clock cycles each row stays driven (≥2).
- DEBOUNCE_FRAMES, 4: consecutive identical scan frames needed to confirm a press or a release (≥1).

Ports:

- clk  in  1: clock.
- RST  in  1: reset, synchronous, active-high.
- row_out  out  4: matrix row drive, active-low, exactly one bit low.
- col_in  in  4: matrix column sense, active-low (externally pulled up), already synchronised.
- accept  in  1: controller can take an event this cycle.
- keypad_input  out  4: digit value. Valid with `read_input`; holds its last value otherwise.
- read_input  out  1: one-cycle digit strobe.
- operator_input  out  3: one-hot operator (001 add/negate, 010 sub, 100 mul) for one cycle, else 000.
- equal_input  out  1: one-cycle equals strobe.
- overrun  out  1: one-cycle pulse when a confirmed event is dropped.

## Operation

- Key map (row,col): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D.
- Encoding:
  - A → 001, B → 010, C → 100.
  - # → equal.
  - Digits → `keypad_input` = value.
  - * and D are confirmed and debounced but generate no event.
- Scanning:
  - `row_out` rotates 1110 → 1101 → 1011 → 0111 → 1110, advancing every SCAN_DIV cycles.
  - `col_in` is sampled on the last cycle of each row slot.
  - A frame is four slots.
- Frame result is one of:
  - NONE: no column low;
  - KEY(code): exactly one key low in the whole frame;
  - MULTI: two or more keys low.
- MULTI counts as neither press nor release. It resets the debounce counter and leaves the state unchanged.
- FSM states:
  - IDLE: count NONE frames. Any KEY → PRESS_DB with the counter at 1.
  - PRESS_DB:
    - Same code again → increment the counter.
    - Counter reaches DEBOUNCE_FRAMES → latch the code into the buffer, go to HELD.
    - Different code or NONE → IDLE.
  - HELD: key down, no further events (no auto-repeat). NONE → RELEASE_DB with the counter at 1. Any KEY keeps HELD.
  - RELEASE_DB:
    - NONE → increment the counter; at DEBOUNCE_FRAMES go to IDLE.
    - KEY → HELD.
- Holding buffer (one entry, valid bit plus code):
  - Emission occurs on the first cycle with `valid & accept`. The matching strobe is driven that cycle and `valid` clears.
  - If a new confirmed event arrives while `valid` is set, the new event is dropped, the old one is kept, and `overrun` pulses.
  - A latch and an emit in the same cycle: the emit takes the old entry and the new entry becomes valid.
  - Events for * and D are never written to the buffer.
- At most one of `read_input`, `operator_input`, `equal_input` is nonzero in any cycle.

## Timing

- Reset (synchronous, RST high at a clk edge) sets:
  - `row_out` = 1110, slot counter 0, FSM = IDLE, debounce counter 0, buffer invalid;
  - all strobes 0, `keypad_input` = 0, `overrun` = 0.
- Reset mid-debounce or mid-hold discards all progress. A key still held after reset must pass PRESS_DB again and then produces one new event.
- Press latency: confirmation happens at the frame end after DEBOUNCE_FRAMES qualifying frames. The buffer is written the next cycle, and the strobe comes the cycle after if `accept` = 1. That is ≤ (DEBOUNCE_FRAMES+1)·4·SCAN_DIV + 2 cycles from a stable press.
- All outputs are registered. Strobes are exactly one cycle wide.

## Structure

- Shared package `calc_keypad_pkg` holds:
  - `key_code_t` (4-bit enum over the 16 keys);
  - `OP_ADD`/`OP_SUB`/`OP_MUL` 3-bit constants, shared with the controller;
  - the `kp_state_t` FSM enum.
- One sub-module: `keypad_row_scanner` (row rotation, slot counter, frame result NONE/KEY/MULTI plus code, frame-done pulse). Debounce FSM, encoding and buffer live in `keypad_encoder`.

## Test plan

Use SCAN_DIV=2, DEBOUNCE_FRAMES=2 for all cases.

- Hold key "7" (r2,c0) for 5 frames, `accept`=1 → exactly one `read_input` pulse, `keypad_input`=7, `operator_input`=000, `equal_input`=0.
- Press B, release, then press # → `operator_input`=010 for one cycle, later `equal_input` for one cycle. No `read_input`.
- Glitch "5" for 1 frame, then NONE → no event. Bounce "3" as 1 frame on / 1 frame off / 3 frames on → one event, value 3.
- Press "1" with `accept`=0, release, press "2" → `overrun` pulses once on "2". Raising `accept` then yields one `read_input` with value 1 only.
- "4" and "6" held together for 4 frames → no event. Release "6" → one event, value 4.
- Assert RST while in HELD with "9" still down → outputs return to reset values. After release of RST, one new event with value 9 follows the debounce latency.
